// File: rtl/conv_kxk_stream_if.sv
// Streaming bus for the KxK convolution engine.
// The pixel input and the result output share one bundle. The producer/consumer
// side uses the master modport and the engine uses the slave modport.
interface conv_kxk_stream_if #(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 32
);
    logic                        in_valid;
    logic signed [BIT_WIDTH-1:0] in_data;
    logic                        out_valid;
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_last;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output out_last
    );
endinterface

// File: rtl/conv_kxk_stream.sv
// Streaming KxK signed convolution engine.
// Pixels arrive in raster order, one per accepted cycle, and enter a K-row
// shift-register line buffer. Only window positions that fit fully inside the
// map produce a result. Each result goes through a three-stage registered
// pipeline (products, row sums, bias plus saturation) and carries its own valid
// and end-of-frame flags, so downstream logic never has to count positions.
module conv_kxk_stream #(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 32,
    parameter int MAP_SIZE  = 32,
    parameter int K         = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [K*K*BIT_WIDTH-1:0]     filter,
    input  logic signed [OUT_WIDTH-1:0]  bias,
    conv_kxk_stream_if.slave             bus
);

    localparam int DEPTH   = K * MAP_SIZE;
    localparam int TAPS    = K * K;
    localparam int PROD_W  = 2 * BIT_WIDTH;
    localparam int ACC_MIN = PROD_W + $clog2(TAPS) + 1;
    localparam int ACC     = (ACC_MIN > OUT_WIDTH + 1) ? ACC_MIN : OUT_WIDTH + 1;
    localparam int CW      = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;

    localparam logic [CW-1:0] LAST_POS  = CW'(MAP_SIZE - 1);
    localparam logic [CW-1:0] FIRST_WIN = CW'(K - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    // Clamp limits of the output range, expressed at accumulator width.
    localparam logic signed [ACC-1:0] SAT_MAX =
        {{(ACC - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC-1:0] SAT_MIN =
        {{(ACC - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    // Line buffer: index 0 is the newest pixel, index a*MAP_SIZE+b is the
    // pixel a rows up and b columns left of the newest one.
    logic signed [BIT_WIDTH-1:0] r_line [DEPTH];
    logic [CW-1:0]               r_col;
    logic [CW-1:0]               r_row;

    // Stage 0: a window was completed by the pixel just shifted in.
    logic                        r_s0Valid;
    logic                        r_s0Last;

    // Stage 1: all K*K products.
    logic signed [PROD_W-1:0]    r_prod [TAPS];
    logic                        r_s1Valid;
    logic                        r_s1Last;

    // Stage 2: one sum per kernel row.
    logic signed [ACC-1:0]       r_rowSum [K];
    logic                        r_s2Valid;
    logic                        r_s2Last;

    // Stage 3: saturated result.
    logic signed [OUT_WIDTH-1:0] r_outData;
    logic                        r_outValid;
    logic                        r_outLast;

    logic                        w_accept;
    logic                        w_launch;
    logic                        w_launchLast;
    logic signed [PROD_W-1:0]    w_prod [TAPS];
    logic signed [ACC-1:0]       w_rowSum [K];
    logic signed [ACC-1:0]       w_total;
    logic signed [OUT_WIDTH-1:0] w_sat;

    assign w_accept     = bus.in_valid;
    assign w_launch     = w_accept && (r_row >= FIRST_WIN) && (r_col >= FIRST_WIN);
    assign w_launchLast = w_launch && (r_row == LAST_POS) && (r_col == LAST_POS);

    // Window taps: kernel row 0 is the oldest row, column 0 the oldest column,
    // so tap (r,c) reads the pixel K-1-r rows up and K-1-c columns left.
    genvar gr, gc;
    generate
        for (gr = 0; gr < K; gr++) begin : g_row
            for (gc = 0; gc < K; gc++) begin : g_col
                logic signed [BIT_WIDTH-1:0] w_pix;
                logic signed [BIT_WIDTH-1:0] w_tap;
                logic signed [PROD_W-1:0]    w_pixExt;
                logic signed [PROD_W-1:0]    w_tapExt;

                assign w_pix    = r_line[(K - 1 - gr) * MAP_SIZE + (K - 1 - gc)];
                assign w_tap    = filter[BIT_WIDTH * (gr * K + gc) +: BIT_WIDTH];
                assign w_pixExt = {{BIT_WIDTH{w_pix[BIT_WIDTH-1]}}, w_pix};
                assign w_tapExt = {{BIT_WIDTH{w_tap[BIT_WIDTH-1]}}, w_tap};
                assign w_prod[gr * K + gc] = w_pixExt * w_tapExt;
            end
        end
    endgenerate

    // Shift the line buffer and advance the raster position on every accepted
    // pixel, and flag whether that pixel completed a valid window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
            end
            r_col     <= '0;
            r_row     <= '0;
            r_s0Valid <= 1'b0;
            r_s0Last  <= 1'b0;
        end else begin
            r_s0Valid <= w_launch;
            r_s0Last  <= w_launchLast;
            if (w_accept) begin
                r_line[0] <= bus.in_data;
                for (int i = 1; i < DEPTH; i++) begin
                    r_line[i] <= r_line[i-1];
                end
                if (r_col == LAST_POS) begin
                    r_col <= '0;
                    r_row <= (r_row == LAST_POS) ? '0 : r_row + ONE;
                end else begin
                    r_col <= r_col + ONE;
                end
            end
        end
    end

    // Capture the window products one cycle after the pixel that completed it,
    // before a following pixel can shift the window away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                r_prod[i] <= '0;
            end
            r_s1Valid <= 1'b0;
            r_s1Last  <= 1'b0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                r_prod[i] <= w_prod[i];
            end
            r_s1Valid <= r_s0Valid;
            r_s1Last  <= r_s0Last;
        end
    end

    // Add the K products of each kernel row at full accumulator width.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            w_rowSum[r] = '0;
            for (int c = 0; c < K; c++) begin
                w_rowSum[r] = w_rowSum[r] + ACC'(r_prod[r * K + c]);
            end
        end
    end

    // Register the per-row partial sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                r_rowSum[r] <= '0;
            end
            r_s2Valid <= 1'b0;
            r_s2Last  <= 1'b0;
        end else begin
            for (int r = 0; r < K; r++) begin
                r_rowSum[r] <= w_rowSum[r];
            end
            r_s2Valid <= r_s1Valid;
            r_s2Last  <= r_s1Last;
        end
    end

    // Combine the rows with the bias and clamp into the output range.
    always_comb begin
        w_total = ACC'(bias);
        for (int r = 0; r < K; r++) begin
            w_total = w_total + r_rowSum[r];
        end
        if (w_total > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_total < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            w_sat = w_total[OUT_WIDTH-1:0];
        end
    end

    // Register the final result and its flags; the data register only moves
    // when a result is present so it holds the last value between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
        end else begin
            r_outValid <= r_s2Valid;
            r_outLast  <= r_s2Valid && r_s2Last;
            if (r_s2Valid) begin
                r_outData <= w_sat;
            end
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign bus.out_last  = r_outLast;

endmodule

// File: doc/conv_kxk_stream.md
# conv_kxk_stream

Streaming KxK signed convolution engine for the LeNet-5 feature-map datapath. It accepts one pixel per cycle in raster order through a valid-qualified input and keeps K rows of the map in an internal shift-register line buffer. It generates only the valid (no-padding) window positions and multiplies each window by a static KxK filter. A registered, pipelined adder tree adds a bias and emits a saturated result with valid and end-of-frame flags, so downstream pooling needs no position counting.

## Interface
- BIT_WIDTH, 8, signed pixel and filter-tap width
- OUT_WIDTH, 32, signed output width (saturating)
- MAP_SIZE, 32, input map width and height in pixels
- K, 5, kernel size (odd or even, 2 ≤ K ≤ MAP_SIZE)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_data is accepted this cycle
- in_data  input  BIT_WIDTH  signed pixel, raster order
- filter  input  K*K*BIT_WIDTH  tap (r,c) at [BIT_WIDTH*(r*K+c) +: BIT_WIDTH]; r=0 is the top (oldest) row, c=0 the left (oldest) column
- bias  input  OUT_WIDTH  signed bias added to every output
- out_valid  output  1  out_data holds a valid window result
- out_data  output  OUT_WIDTH  signed saturated convolution result
- out_last  output  1  high with the final out_valid of a frame

## Operation
- Line buffer: K*MAP_SIZE entries chained as one shift register. On an accepted pixel (in_valid=1), everything shifts by one and in_data enters the newest slot. The window is the last K entries of each of the K row segments. With in_valid=0, the buffer and counters hold.
- Position counters col, row (0..MAP_SIZE-1) track the coordinate of the pixel being accepted. col wraps to 0 and row increments; after (MAP_SIZE-1, MAP_SIZE-1), both wrap to 0 and the next pixel starts a new frame with no gap. Buffer contents are not cleared between frames.
- Window valid: an accepted pixel at (row,col) with row ≥ K-1 and col ≥ K-1 launches a result. The result covers input rows row-K+1..row and columns col-K+1..col. Each frame has exactly (MAP_SIZE-K+1)^2 results, in raster order.
- Arithmetic: products are full precision, signed × signed, 2*BIT_WIDTH bits. The accumulator is ACC = 2*BIT_WIDTH + clog2(K*K) + 1 bits, widened to at least OUT_WIDTH+1. Bias is sign-extended into ACC.
- Saturation: the final sum clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; no wrap-around.
- Pipeline, three register stages, each carrying its own valid bit and last flag:
  - S1: K*K products registered.
  - S2: K per-row sums registered.
  - S3: sum of rows plus bias, saturated, registered to out_data.
- The pipeline always advances: in_valid=0 creates bubbles but never stalls results in flight. There is no output backpressure.
- filter and bias must be stable while any launched result is in flight; they are sampled at S1 and S3 respectively.
- out_last is set on the result launched by pixel (MAP_SIZE-1, MAP_SIZE-1).

## Timing
- Reset (asynchronous assert) clears:
  - out_valid=0, out_data=0, out_last=0;
  - all pipeline valid bits;
  - row=col=0;
  - all line-buffer entries to 0.
- Reset release: the first rising edge with rst=0 and in_valid=1 accepts pixel (0,0).
- Latency: a pixel accepted at edge n whose window is valid gives out_valid=1 after edge n+3. Throughput is one result per accepted pixel.
- Reset mid-frame: in-flight results are discarded, no out_valid is generated, and the next accepted pixel is treated as (0,0).
- in_valid toggling every cycle: the output sequence and values are identical to continuous input, only spread in time.
- Back-to-back frames: the first result of frame f+1 cannot appear until K-1 rows plus K pixels into that frame. Frame f's last result is never merged with frame f+1.

## Test plan
- Reset check: assert rst with garbage on inputs → out_valid=0, out_data=0, out_last=0 during and after reset until a valid window is produced.
- Constant image (MAP_SIZE=8, K=5): all pixels 1, all taps 1, bias 3 → exactly 16 results, each 28. The first result arrives 3 cycles after pixel (4,4); out_last is on the 16th result only.
- Tap-position image (MAP_SIZE=8, K=3): pixel (r,c)=r*8+c, only tap (0,0)=1, others 0, bias 0 → result i,j equals (i)*8+(j) for i,j in 0..5, in raster order. Repeat with tap (2,2)=1 → (i+2)*8+(j+2).
- Stall: same stimulus with in_valid deasserted on random cycles (about 50%) → identical value sequence and count to the continuous run; out_valid never high without a matching launch.
- Saturation (OUT_WIDTH=16, K=5): pixels -128, taps -128, bias 0 → sum 409600, clamps to 32767. Pixels 127, taps -128 → clamps to -32768.
- Reset mid-frame: assert rst after 20 pixels of frame 1, then stream a full frame → no spurious outputs, and the results match a clean single frame exactly.
